// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and types: register-file geometry, the
// hard-wired zero register and the scoreboard counter type.
package pipeline_pkg;

  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;
  localparam int CNT_W    = 2;

  typedef logic [IDX_W-1:0] reg_index_t;
  typedef logic [CNT_W-1:0] count_t;

  localparam reg_index_t ZERO_REG = '0;
  localparam count_t     CNT_MAX  = '1;

  // Register 0 is never tracked, so it can never cause a hazard.
  function automatic logic is_live(input reg_index_t idx);
    return idx != ZERO_REG;
  endfunction

endpackage

// File: rtl/scoreboard_counter.sv
// One in-flight writer counter for a single architectural register, with a
// sticky flag raised when a writeback arrives while nothing is pending.
module scoreboard_counter
  import pipeline_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   inc,
  input  logic   dec,
  output count_t count,
  output logic   underflow
);

  // inc and dec together cancel; the issue side never increments at max
  // because saturation stalls decode, but the guard keeps the count honest.
  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (count != CNT_MAX) count <= count + count_t'(1);
        end
        2'b01: begin
          if (count != '0) count <= count - count_t'(1);
          else             underflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/register_scoreboard.sv
// Decode-stage issue control: per-register in-flight write tracking, RAW and
// counter-saturation stall generation, and a registered pending-writer mask.
module register_scoreboard
  import pipeline_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  reg_index_t          issue_rs,
  input  reg_index_t          issue_rt,
  input  logic                issue_uses_rs,
  input  logic                issue_uses_rt,
  input  logic                issue_writes,
  input  reg_index_t          issue_dest,
  input  logic                wb_valid,
  input  reg_index_t          wb_index,
  output logic                stall,
  output logic                issue_accept,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                wb_underflow_err
);

  count_t              cnt [NUM_REGS];
  logic [NUM_REGS-1:1] inc_vec;
  logic [NUM_REGS-1:1] dec_vec;
  logic [NUM_REGS-1:1] under_vec;
  logic                raw_rs;
  logic                raw_rt;
  logic                sat;

  assign cnt[0] = '0;

  // Hazards look only at registered counts, so a same-cycle writeback never
  // releases a stall early; the source becomes readable the following cycle.
  always_comb begin
    raw_rs = issue_uses_rs & is_live(issue_rs) & (cnt[issue_rs] != '0);
    raw_rt = issue_uses_rt & is_live(issue_rt) & (cnt[issue_rt] != '0);
    sat    = issue_writes & is_live(issue_dest) & (cnt[issue_dest] == CNT_MAX);
  end

  assign stall        = issue_valid & (raw_rs | raw_rt | sat);
  assign issue_accept = issue_valid & ~stall;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      inc_vec[i] = issue_accept & issue_writes & (issue_dest == reg_index_t'(i));
      dec_vec[i] = wb_valid & (wb_index == reg_index_t'(i));
    end
  end

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    scoreboard_counter u_cnt (
      .clock     (clock),
      .reset     (reset),
      .inc       (inc_vec[i]),
      .dec       (dec_vec[i]),
      .count     (cnt[i]),
      .underflow (under_vec[i])
    );
    assign pending_mask[i] = (cnt[i] != '0);
  end

  assign pending_mask[0]  = 1'b0;
  assign wb_underflow_err = |under_vec;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard: hand-computed stall/accept,
// pending_mask and underflow expectations across the issue scenarios.
module tb_register_scoreboard;
  import pipeline_pkg::*;

  logic                clock = 1'b0;
  logic                reset;
  logic                issue_valid;
  reg_index_t          issue_rs;
  reg_index_t          issue_rt;
  logic                issue_uses_rs;
  logic                issue_uses_rt;
  logic                issue_writes;
  reg_index_t          issue_dest;
  logic                wb_valid;
  reg_index_t          wb_index;
  logic                stall;
  logic                issue_accept;
  logic [NUM_REGS-1:0] pending_mask;
  logic                wb_underflow_err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  register_scoreboard dut (
    .clock            (clock),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .issue_rs         (issue_rs),
    .issue_rt         (issue_rt),
    .issue_uses_rs    (issue_uses_rs),
    .issue_uses_rt    (issue_uses_rt),
    .issue_writes     (issue_writes),
    .issue_dest       (issue_dest),
    .wb_valid         (wb_valid),
    .wb_index         (wb_index),
    .stall            (stall),
    .issue_accept     (issue_accept),
    .pending_mask     (pending_mask),
    .wb_underflow_err (wb_underflow_err)
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, then let combinational outputs settle.
  task automatic apply_stimulus(input logic v, input int rs, input logic urs, input int rt,
                                input logic urt, input logic wr, input int dest,
                                input logic wbv, input int wbi);
    issue_valid   = v;
    issue_rs      = reg_index_t'(rs);
    issue_uses_rs = urs;
    issue_rt      = reg_index_t'(rt);
    issue_uses_rt = urt;
    issue_writes  = wr;
    issue_dest    = reg_index_t'(dest);
    wb_valid      = wbv;
    wb_index      = reg_index_t'(wbi);
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step();
    step();
    check_output("reset_mask", pending_mask, 32'h0);
    check_output("reset_err", {31'b0, wb_underflow_err}, 32'h0);
    reset = 1'b0;

    // Independent issue writing r5.
    apply_stimulus(1, 3, 1, 4, 1, 1, 5, 0, 0);
    check_output("t1_stall", {31'b0, stall}, 32'h0);
    check_output("t1_accept", {31'b0, issue_accept}, 32'h1);
    step();
    idle();
    check_output("t1_mask", pending_mask, 32'h20);

    // RAW on r5, released one cycle after writeback.
    apply_stimulus(1, 5, 1, 0, 0, 0, 0, 0, 0);
    check_output("t2_raw_stall", {31'b0, stall}, 32'h1);
    check_output("t2_raw_accept", {31'b0, issue_accept}, 32'h0);
    step();
    apply_stimulus(1, 5, 1, 0, 0, 0, 0, 1, 5);
    check_output("t2_wb_same_cycle_stall", {31'b0, stall}, 32'h1);
    step();
    apply_stimulus(1, 5, 1, 0, 0, 0, 0, 0, 0);
    check_output("t2_after_wb_stall", {31'b0, stall}, 32'h0);
    check_output("t2_after_wb_accept", {31'b0, issue_accept}, 32'h1);
    check_output("t2_after_wb_mask", pending_mask, 32'h0);
    step();
    idle();

    // Saturate r7 with back-to-back writes.
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1, 0, 0, 0, 0, 1, 7, 0, 0);
      check_output($sformatf("t3_write%0d_accept", k), {31'b0, issue_accept}, 32'h1);
      step();
    end
    apply_stimulus(1, 0, 0, 0, 0, 1, 7, 0, 0);
    check_output("t3_mask_r7", pending_mask, 32'h80);
    check_output("t3_sat_stall", {31'b0, stall}, 32'h1);
    step();
    apply_stimulus(1, 0, 0, 0, 0, 1, 7, 1, 7);
    check_output("t3_sat_wb_same_cycle", {31'b0, stall}, 32'h1);
    step();
    apply_stimulus(1, 0, 0, 0, 0, 1, 7, 0, 0);
    check_output("t3_after_wb_accept", {31'b0, issue_accept}, 32'h1);
    step();
    apply_stimulus(1, 0, 0, 0, 0, 1, 7, 0, 0);
    check_output("t3_resaturated_stall", {31'b0, stall}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 7);
      step();
    end
    idle();
    check_output("t3_drained_mask", pending_mask, 32'h0);

    // Simultaneous accept and writeback on r9 with one writer pending.
    apply_stimulus(1, 0, 0, 0, 0, 1, 9, 0, 0);
    step();
    apply_stimulus(1, 0, 0, 0, 0, 1, 9, 1, 9);
    check_output("t4_accept", {31'b0, issue_accept}, 32'h1);
    step();
    idle();
    check_output("t4_mask_r9", pending_mask, 32'h200);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 9);
    step();
    idle();
    check_output("t4_drained_mask", pending_mask, 32'h0);
    check_output("t4_no_err", {31'b0, wb_underflow_err}, 32'h0);

    // Underflow: r0 is ignored, r12 with nothing pending flags sticky error.
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    idle();
    check_output("t5_wb_r0_no_err", {31'b0, wb_underflow_err}, 32'h0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 12);
    step();
    idle();
    check_output("t5_underflow_err", {31'b0, wb_underflow_err}, 32'h1);
    check_output("t5_underflow_mask", pending_mask, 32'h0);
    step();
    step();
    check_output("t5_err_sticky", {31'b0, wb_underflow_err}, 32'h1);

    // Register 0 traffic never stalls and is never tracked.
    apply_stimulus(1, 0, 0, 0, 0, 1, 5, 0, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1, 0, 1, 0, 1, 1, 0, 0, 0);
      check_output($sformatf("t6_zero_stall%0d", k), {31'b0, stall}, 32'h0);
      step();
    end
    apply_stimulus(1, 5, 0, 5, 0, 0, 0, 0, 0);
    check_output("t6_unused_src_stall", {31'b0, stall}, 32'h0);
    idle();
    check_output("t6_mask_only_r5", pending_mask, 32'h20);

    // Reset mid-flight drops tracking and ignores that cycle's issue.
    reset = 1'b1;
    apply_stimulus(1, 0, 0, 0, 0, 1, 6, 0, 0);
    step();
    reset = 1'b0;
    idle();
    check_output("t7_reset_mask", pending_mask, 32'h0);
    check_output("t7_reset_err", {31'b0, wb_underflow_err}, 32'h0);
    apply_stimulus(1, 5, 1, 6, 1, 0, 0, 0, 0);
    check_output("t7_post_reset_stall", {31'b0, stall}, 32'h0);
    step();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_scoreboard.md
# register_scoreboard

Issue-control block for the decode stage: tracks which architectural registers have a write in flight down the pipeline and holds the decoded instruction until its source operands are safe to read from the register file. Sits beside the decode stage, fed by decode-side issue requests and by the writeback stage's register-write strobe. Produces a stall/accept decision each cycle and a per-register pending mask for debug and the future forwarding unit.

## Interface
- NUM_REGS, 32, architectural register count; index 0 is hard-wired zero
- IDX_W, 5, register index width (log2 NUM_REGS)
- CNT_W, 2, per-register in-flight writer counter width; max in flight = 2^CNT_W − 1

- clock  in  1  single clock domain; all state updates on rising edge
- reset  in  1  synchronous, active-high
- issue_valid  in  1  decode presents an instruction this cycle
- issue_rs  in  IDX_W  first source index
- issue_rt  in  IDX_W  second source index
- issue_uses_rs  in  1  instruction reads rs
- issue_uses_rt  in  1  instruction reads rt
- issue_writes  in  1  instruction writes a destination register
- issue_dest  in  IDX_W  destination index (rt or rd, already selected by decode)
- wb_valid  in  1  writeback commits a register write this cycle (same strobe as RegWrite)
- wb_index  in  IDX_W  register written by writeback
- stall  out  1  decode must hold its instruction
- issue_accept  out  1  issue_valid & ~stall
- pending_mask  out  NUM_REGS  bit i set when counter i is nonzero; bit 0 always 0
- wb_underflow_err  out  1  sticky: writeback arrived for a register with zero pending writers

## Operation
- State: one CNT_W-bit counter per register 1..NUM_REGS−1; register 0 has no counter (reads as 0).
- Hazard terms, from registered counters only:
  - raw_rs = issue_uses_rs & (issue_rs != 0) & cnt[issue_rs] != 0
  - raw_rt = issue_uses_rt & (issue_rt != 0) & cnt[issue_rt] != 0
  - sat = issue_writes & (issue_dest != 0) & cnt[issue_dest] == max
- stall = issue_valid & (raw_rs | raw_rt | sat); stall is 0 when issue_valid is 0.
- No same-cycle bypass: a writeback in cycle N does not clear a stall in cycle N; the source becomes readable from cycle N+1 (register file write lands on the same edge).
- Counter update per register i each edge:
  - inc = issue_accept & issue_writes & issue_dest == i
  - dec = wb_valid & wb_index == i
  - inc & dec: unchanged; inc only: +1; dec only with cnt>0: −1
  - dec only with cnt==0: counter stays 0, wb_underflow_err sets and holds until reset
- Destination 0: accepted, never counted. wb_index 0: ignored, never flags error.
- Instruction whose dest equals its own source: RAW check uses pre-issue counter; accepted instruction then increments.

## Timing
- Reset (synchronous): all counters 0, pending_mask 0, wb_underflow_err 0; stall/issue_accept combinational and valid in the reset cycle (counters already 0 → no stall from hazards).
- reset asserted mid-operation discards all in-flight tracking on that edge; inputs in the reset cycle do not update counters.
- stall, issue_accept: combinational, same cycle as issue inputs; no registered latency.
- pending_mask: registered view, updates one edge after the causing issue/writeback.
- Decode holds issue_* stable while stall=1; block imposes no other handshake ordering.
- Throughput: one accept per cycle when hazard-free.

## Structure
- Shared package (pipeline_pkg): NUM_REGS, IDX_W, CNT_W, ZERO_REG constant, reg_index_t typedef.
- Sub-module scoreboard_counter: one CNT_W counter with inc/dec/underflow output, instantiated per register 1..NUM_REGS−1 via generate; top does index decode, hazard logic, error OR-reduce.

## Test plan
- Reset, then issue rs=3 rt=4 uses both, dest=5 → stall=0, accept=1; next cycle pending_mask=0x20.
- Pending r5, issue uses_rs rs=5 → stall=1 held; wb_valid wb_index=5 in cycle N → stall still 1 in N, 0 in N+1, mask bit 5 cleared.
- Three accepted writes to r7 without writeback → cnt=3; fourth write to r7 → stall=1 (sat); one writeback → accepted next cycle.
- Same-cycle accept dest=9 and wb_index=9 with cnt=1 → cnt stays 1, mask bit 9 stays set.
- wb_valid wb_index=12 with cnt=0 → wb_underflow_err=1 next cycle, persists until reset; wb_index=0 → no error.
- Issue dest=0 and rs=0 with other traffic pending → never stalls, mask bit 0 stays 0; reset mid-flight with r5 pending → mask=0, later reads of r5 not stalled.
